// File: rtl/float_mul_pkg.sv
// Shared types and constants for the float multiplier issue stage.
package float_mul_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    HOLD
  } issue_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/float_multi_issue_if.sv
// Operand stream, multiplier handshake and result stream of the issue stage.
interface float_multi_issue_if #(
  parameter int DEPTH = 4
) ();
  import float_mul_pkg::*;

  logic                       In_Valid;
  logic                       In_Ready;
  logic [FP_W-1:0]            In_A;
  logic [FP_W-1:0]            In_B;
  logic [FP_W-1:0]            Mul_A;
  logic [FP_W-1:0]            Mul_B;
  logic                       Mul_Start;
  logic [3:0]                 Mul_Done;
  logic [FP_W-1:0]            Mul_Result;
  logic                       Out_Valid;
  logic                       Out_Ready;
  logic [FP_W-1:0]            Out_Result;
  logic                       Out_Err;
  logic [$clog2(DEPTH+1)-1:0] Count;
  logic                       Busy;

  modport slave (
    input  In_Valid, In_A, In_B, Mul_Done, Mul_Result, Out_Ready,
    output In_Ready, Mul_A, Mul_B, Mul_Start, Out_Valid, Out_Result, Out_Err,
           Count, Busy
  );

  modport master (
    output In_Valid, In_A, In_B, Mul_Done, Mul_Result, Out_Ready,
    input  In_Ready, Mul_A, Mul_B, Mul_Start, Out_Valid, Out_Result, Out_Err,
           Count, Busy
  );

endinterface

// File: rtl/float_operand_fifo.sv
// Synchronous FIFO of operand pairs; pushes when full and pops when empty are dropped.
module float_operand_fifo
  import float_mul_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  operand_pair_t data_i,
  input  logic          pop_i,
  output operand_pair_t data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  operand_pair_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/float_multi_issue.sv
// Issues buffered operand pairs to the multiplier one at a time, with a watchdog
// that turns a multiplication that never completes into a quiet-NaN error result.
module float_multi_issue
  import float_mul_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic CLK,
  input logic RST,
  float_multi_issue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT);

  issue_state_e    state_q, state_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [FP_W-1:0] mul_a_q, mul_a_d;
  logic [FP_W-1:0] mul_b_q, mul_b_d;
  logic            mul_start_q, mul_start_d;
  logic            out_valid_q, out_valid_d;
  logic [FP_W-1:0] out_result_q, out_result_d;
  logic            out_err_q, out_err_d;

  operand_pair_t   in_pair;
  operand_pair_t   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            pop;
  logic            unused_done_hi;

  assign in_pair        = '{a: bus.In_A, b: bus.In_B};
  assign unused_done_hi = ^bus.Mul_Done[3:1];

  float_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (bus.In_Valid),
    .data_i  (in_pair),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_start_d  = mul_start_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    pop          = 1'b0;

    if (out_valid_q && bus.Out_Ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !out_valid_q) begin
          pop         = 1'b1;
          mul_a_d     = head.a;
          mul_b_d     = head.b;
          mul_start_d = 1'b1;
          wdog_d      = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Done is checked first so it wins over a timeout in the same cycle.
        if (bus.Mul_Done[0]) begin
          out_result_d = bus.Mul_Result;
          out_err_d    = 1'b0;
          out_valid_d  = 1'b1;
          mul_start_d  = 1'b0;
          state_d      = GAP;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          out_result_d = FP_QNAN;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
          mul_start_d  = 1'b0;
          state_d      = GAP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      GAP:     state_d = HOLD;
      HOLD:    if (!out_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_start_q  <= mul_start_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.In_Ready   = !fifo_full;
  assign bus.Mul_A      = mul_a_q;
  assign bus.Mul_B      = mul_b_q;
  assign bus.Mul_Start  = mul_start_q;
  assign bus.Out_Valid  = out_valid_q;
  assign bus.Out_Result = out_result_q;
  assign bus.Out_Err    = out_err_q;
  assign bus.Count      = fifo_count;
  assign bus.Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_float_multi_issue.sv
// Bench for float_multi_issue: behavioural multiplier, random consumer, and an
// in-order expected-result queue derived from the pushed operands.
module tb_float_multi_issue;

  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam logic [31:0] SKIP_A = 32'h3F800001;  // the multiplier never finishes this operand
  localparam int          LIMIT  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_multi_issue_if #(.DEPTH(4)) bus ();
  float_multi_issue #(.DEPTH(4), .TIMEOUT(64)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  int   lat = 4;
  bit   lat_rand = 1'b0;
  bit   junk_hi = 1'b0;
  bit   use_force = 1'b0;
  logic [3:0] force_done = 4'b0000;
  bit   rdy_fixed = 1'b1;
  bit   rdy_rand = 1'b0;

  int   hi_cnt = 0;
  int   lat_cur = 4;
  int   run = 0;
  int   rises = 0;
  int   unstable = 0;
  int   hi_lens[$];
  logic [31:0] held_a, held_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Truncating single-precision multiply for normal operands with in-range results.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [32:0] ref_out(input logic [31:0] a, input logic [31:0] b);
    return (a == SKIP_A) ? {1'b1, QNAN} : {1'b0, fmul(a, b)};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // Multiplier model: done pulses after lat_cur cycles of Start, or never for SKIP_A.
  initial begin
    bus.Mul_Done   = 4'b0000;
    bus.Mul_Result = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.Mul_Start) begin
        hi_cnt++;
        if (hi_cnt == 1) lat_cur = lat_rand ? $urandom_range(1, 8) : lat;
      end else begin
        hi_cnt = 0;
      end
      bus.Mul_Result = fmul(bus.Mul_A, bus.Mul_B);
      if (use_force) bus.Mul_Done = force_done;
      else bus.Mul_Done = {junk_hi ? 3'($urandom) : 3'b000,
                           bus.Mul_Start && (bus.Mul_A != SKIP_A) && (hi_cnt == lat_cur)};
    end
  end

  // Consumer: chooses Out_Ready, records every accepted result.
  initial begin
    bus.Out_Ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.Out_Ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
      if (bus.Out_Valid && bus.Out_Ready) got_q.push_back({bus.Out_Err, bus.Out_Result});
    end
  end

  // Start-pulse monitor: counts pulses, their lengths, and operand changes while high.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.Mul_Start) begin
        if (run == 0) begin
          rises++;
          held_a = bus.Mul_A;
          held_b = bus.Mul_B;
        end else if (bus.Mul_A != held_a || bus.Mul_B != held_b) begin
          unstable++;
        end
        run++;
      end else if (run != 0) begin
        hi_lens.push_back(run);
        run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp_v);
    int n = 0;
    @(negedge clk);
    bus.In_Valid = 1'b1;
    bus.In_A     = a;
    bus.In_B     = b;
    while (!bus.In_Ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 64'(n < LIMIT), 64'd1);
    @(posedge clk);
    exp_q.push_back(exp_v);
    #1 bus.In_Valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((got_q.size() < exp_q.size() || bus.Busy || bus.Count != 0) && n < 4 * LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(n < 4 * LIMIT), 64'd1);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() != 0 && got_q.size() != 0) check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int r0, h0;
    logic [31:0] a, b;
    bus.In_Valid = 1'b0;
    bus.In_A     = '0;
    bus.In_B     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", 64'(bus.Mul_Start), 64'd0);
    check("rst_mul_a", 64'(bus.Mul_A), 64'd0);
    check("rst_mul_b", 64'(bus.Mul_B), 64'd0);
    check("rst_valid", 64'(bus.Out_Valid), 64'd0);
    check("rst_result", 64'(bus.Out_Result), 64'd0);
    check("rst_err", 64'(bus.Out_Err), 64'd0);
    check("rst_count", 64'(bus.Count), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_in_ready", 64'(bus.In_Ready), 64'd1);
    rst = 1'b0;

    // Single product, 4-cycle multiplier.
    r0 = rises;
    push(32'h40200000, 32'h40A00000, {1'b0, 32'h41480000});
    drain("single");
    check("single_pulses", 64'(rises - r0), 64'd1);
    check("single_hi_len", 64'(hi_lens[$]), 64'd4);

    // Ordering.
    push(32'h40000000, 32'h40000000, {1'b0, 32'h40800000});
    push(32'h3E000000, 32'h3E000000, {1'b0, 32'h3C800000});
    push(32'h44800000, 32'h43800000, {1'b0, 32'h48800000});
    drain("order");

    // Backpressure: results held, FIFO fills, sixth pair stalls.
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a = rand_fp();
      b = rand_fp();
      push(a, b, ref_out(a, b));
    end
    a = rand_fp();
    b = rand_fp();
    @(negedge clk);
    bus.In_Valid = 1'b1;
    bus.In_A     = a;
    bus.In_B     = b;
    repeat (10) @(negedge clk);
    check("bp_count", 64'(bus.Count), 64'd4);
    check("bp_in_ready", 64'(bus.In_Ready), 64'd0);
    check("bp_valid", 64'(bus.Out_Valid), 64'd1);
    check("bp_busy", 64'(bus.Busy), 64'd1);
    r0 = rises;
    repeat (20) @(negedge clk);
    check("bp_no_issue", 64'(rises - r0), 64'd0);
    check("bp_start_low", 64'(bus.Mul_Start), 64'd0);
    rdy_fixed = 1'b1;
    begin
      int n = 0;
      while (!bus.In_Ready && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      check("bp_pair6_accept", 64'(n < LIMIT), 64'd1);
    end
    @(posedge clk);
    exp_q.push_back(ref_out(a, b));
    #1 bus.In_Valid = 1'b0;
    drain("bp");

    // Watchdog abort, then normal issue; then done on the very last watchdog cycle.
    h0 = hi_lens.size();
    push(SKIP_A, 32'h40000000, {1'b1, QNAN});
    push(32'h40400000, 32'h40000000, {1'b0, 32'h40C00000});
    drain("timeout");
    check("to_hi_len", 64'(hi_lens[h0]), 64'd64);
    check("to_next_len", 64'(hi_lens[h0 + 1]), 64'd4);
    lat = 64;
    push(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    drain("done_wins");
    check("done_wins_len", 64'(hi_lens[$]), 64'd64);
    lat = 4;

    // Spurious done in IDLE, ignored upper bits, then a real done.
    use_force  = 1'b1;
    force_done = 4'b0001;
    repeat (4) @(negedge clk);
    check("spur_idle_valid", 64'(bus.Out_Valid), 64'd0);
    check("spur_idle_busy", 64'(bus.Busy), 64'd0);
    force_done = 4'b1110;
    push(32'h40A00000, 32'h40A00000, {1'b0, 32'h41C80000});
    repeat (10) @(negedge clk);
    check("spur_hi_start", 64'(bus.Mul_Start), 64'd1);
    check("spur_hi_valid", 64'(bus.Out_Valid), 64'd0);
    force_done = 4'b0001;
    @(negedge clk);
    check("spur_done_start", 64'(bus.Mul_Start), 64'd0);
    check("spur_done_valid", 64'(bus.Out_Valid), 64'd1);
    force_done = 4'b0000;
    use_force  = 1'b0;
    drain("spur");

    // Reset while a pair is in ISSUE and two more are queued.
    lat = 20;
    for (int i = 0; i < 3; i++) push(rand_fp(), rand_fp(), 33'd0);
    @(negedge clk);
    check("mid_count", 64'(bus.Count), 64'd2);
    check("mid_start", 64'(bus.Mul_Start), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_start", 64'(bus.Mul_Start), 64'd0);
    check("mid_rst_count", 64'(bus.Count), 64'd0);
    check("mid_rst_valid", 64'(bus.Out_Valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.In_Ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    repeat (5) @(negedge clk);
    check("post_rst_busy", 64'(bus.Busy), 64'd0);
    check("post_rst_results", 64'(got_q.size()), 64'd0);
    lat = 4;

    // Random traffic: random latency, aborts, junk done bits, random backpressure.
    lat_rand = 1'b1;
    rdy_rand = 1'b1;
    junk_hi  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) == 0) ? SKIP_A : rand_fp();
      b = rand_fp();
      push(a, b, ref_out(a, b));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("random");
    check("operands_stable", 64'(unstable), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
